// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - timed RED/GREEN/YELLOW phase sequencer with flashing-yellow fallback
// Optional pedestrian request handling is enabled by defining PED_REQ_EN.
module traffic_sequencer #(
    parameter int TICK_DIV    = 4,
    parameter int RED_T       = 6,
    parameter int GREEN_T     = 8,
    parameter int YELLOW_T    = 2,
    parameter int MIN_GREEN_T = 3,
    parameter int FLASH_T     = 2,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
`ifdef PED_REQ_EN
    input  logic          ped_req,
    output logic          walk,
`endif
    output logic [1:0]    state,
    output logic [CW-1:0] remaining
);

    typedef enum logic [2:0] {
        S_RED,
        S_GREEN,
        S_YELLOW,
        S_FLASH_ON,
        S_FLASH_OFF
    } fsm_t;

    localparam logic [CW-1:0] RED_L    = CW'(RED_T);
    localparam logic [CW-1:0] GREEN_L  = CW'(GREEN_T);
    localparam logic [CW-1:0] YELLOW_L = CW'(YELLOW_T);
    localparam logic [CW-1:0] FLASH_L  = CW'(FLASH_T);
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

    fsm_t          fsm, fsm_n;
    logic [CW-1:0] presc, presc_n;
    logic [CW-1:0] rem_n;
    logic          tick, expire, normal, cut;

`ifdef PED_REQ_EN
    // Completed green ticks reach MIN_GREEN_T once remaining drops to this value.
    localparam logic [CW-1:0] PED_CUT = CW'(GREEN_T + 1 - MIN_GREEN_T);
    logic ped_pending, pend_n, walk_n;
`endif

    assign tick   = (presc == DIV_LAST);
    assign expire = tick && (remaining == CW'(1));
    assign normal = (fsm == S_RED) || (fsm == S_GREEN) || (fsm == S_YELLOW);

    always_comb begin
        fsm_n   = fsm;
        presc_n = tick ? '0 : presc + CW'(1);
        rem_n   = tick ? remaining - CW'(1) : remaining;
`ifdef PED_REQ_EN
        walk_n  = walk;
        pend_n  = ped_pending | (ped_req & ~walk);
        cut     = ped_pending && tick && (remaining <= PED_CUT);
`else
        cut     = 1'b0;
`endif
        if (normal && !en) begin
            fsm_n   = S_FLASH_ON;
            rem_n   = FLASH_L;
            presc_n = '0;
`ifdef PED_REQ_EN
            walk_n  = 1'b0;
            pend_n  = 1'b0;
`endif
        end else if (!normal && en) begin
            fsm_n   = S_RED;
            rem_n   = RED_L;
            presc_n = '0;
        end else begin
            case (fsm)
                S_RED: if (expire) begin
                    fsm_n   = S_GREEN;
                    rem_n   = GREEN_L;
                    presc_n = '0;
`ifdef PED_REQ_EN
                    walk_n  = 1'b0;
`endif
                end
                S_GREEN: if (expire || cut) begin
                    fsm_n   = S_YELLOW;
                    rem_n   = YELLOW_L;
                    presc_n = '0;
                end
                S_YELLOW: if (expire) begin
                    fsm_n   = S_RED;
                    rem_n   = RED_L;
                    presc_n = '0;
`ifdef PED_REQ_EN
                    // Serving the request consumes it; a press in this same cycle is absorbed.
                    if (ped_pending) begin
                        walk_n = 1'b1;
                        pend_n = 1'b0;
                    end
`endif
                end
                S_FLASH_ON: if (expire) begin
                    fsm_n   = S_FLASH_OFF;
                    rem_n   = FLASH_L;
                    presc_n = '0;
                end
                S_FLASH_OFF: if (expire) begin
                    fsm_n   = S_FLASH_ON;
                    rem_n   = FLASH_L;
                    presc_n = '0;
                end
                default: begin
                    fsm_n   = S_RED;
                    rem_n   = RED_L;
                    presc_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_RED;
            presc     <= '0;
            remaining <= RED_L;
`ifdef PED_REQ_EN
            walk        <= 1'b0;
            ped_pending <= 1'b0;
`endif
        end else begin
            fsm       <= fsm_n;
            presc     <= presc_n;
            remaining <= rem_n;
`ifdef PED_REQ_EN
            walk        <= walk_n;
            ped_pending <= pend_n;
`endif
        end
    end

    always_comb begin
        case (fsm)
            S_RED:       state = 2'b00;
            S_GREEN:     state = 2'b01;
            S_YELLOW:    state = 2'b10;
            S_FLASH_ON:  state = 2'b10;
            default:     state = 2'b11;
        endcase
    end

endmodule
